// File: rtl/otter_pkg.sv
// otter_pkg: shared definitions for the OTTER multicycle control unit.
//   cu_state_t      - control-unit state encoding (3 bits, exposed on CU_STATE)
//   OPC_*           - RV32I major opcodes decoded in EXEC
//   FUNC3_MRET      - func3 of the SYSTEM instruction treated as mret
//   exec_strobes_t  - strobe set produced by the EXEC decoder
package otter_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } cu_state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] FUNC3_MRET = 3'b000;

    typedef struct packed {
        logic pc_write;
        logic reg_write;
        logic mem_rden2;
        logic mem_we2;
        logic csr_we;
        logic mret;
        logic is_load;   // load needs a WB cycle, so PC is not advanced in EXEC
    } exec_strobes_t;

endpackage

// File: rtl/otter_cu_decoder.sv
// otter_cu_decoder: purely combinational opcode/func3 -> EXEC strobe set.
//   opcode_i [6:0]  instruction[6:0]
//   func3_i  [2:0]  instruction[14:12]
//   strb_o          exec_strobes_t strobe set for the EXEC cycle
// Build option: OTTER_INTR_EN - when undefined, mret decodes as a NOP.
module otter_cu_decoder
    import otter_pkg::*;
(
    input  logic [6:0]    opcode_i,
    input  logic [2:0]    func3_i,
    output exec_strobes_t strb_o
);

    always_comb begin
        strb_o = '0;
        case (opcode_i)
            OPC_LOAD: begin
                strb_o.mem_rden2 = 1'b1;
                strb_o.is_load   = 1'b1;
            end
            OPC_STORE: begin
                strb_o.mem_we2  = 1'b1;
                strb_o.pc_write = 1'b1;
            end
            OPC_BRANCH: strb_o.pc_write = 1'b1;
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OPIMM: begin
                strb_o.pc_write  = 1'b1;
                strb_o.reg_write = 1'b1;
            end
            OPC_SYSTEM: begin
                strb_o.pc_write = 1'b1;
                if (func3_i == FUNC3_MRET) begin
`ifdef OTTER_INTR_EN
                    strb_o.mret = 1'b1;
`endif
                end else begin
                    strb_o.csr_we    = 1'b1;
                    strb_o.reg_write = 1'b1;
                end
            end
            default: strb_o.pc_write = 1'b1;   // unknown opcodes retire as NOP
        endcase
    end

endmodule

// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: multicycle control-unit FSM for the OTTER RV32I core.
//   clk, RST (sync, active-high)        clock / reset
//   CU_INTR, CU_MIE                      interrupt request (level) and mstatus.MIE
//   CU_OPCODE, CU_FUNC3                  current instruction fields
//   RST_OUT                              reset to PC / register file while in INIT
//   PC_WRITE, REG_WRITE, MEM_RDEN1/2,
//   MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC  per-state strobes
//   CU_STATE                             current state (debug)
// Parameter: INIT_CYCLES (1..16) cycles spent in INIT.
// Build option: OTTER_INTR_EN - enables the pending latch and the INTR state.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int INIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       CU_INTR,
    input  logic       CU_MIE,
    input  logic [6:0] CU_OPCODE,
    input  logic [2:0] CU_FUNC3,
    output logic       RST_OUT,
    output logic       PC_WRITE,
    output logic       REG_WRITE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       MRET_EXEC,
    output logic [2:0] CU_STATE
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    cu_state_t     state_q, state_d;
    logic [3:0]    init_cnt_q, init_cnt_d;
    exec_strobes_t dec;
    logic          mret_now;
    logic          take_intr;

    otter_cu_decoder u_dec (
        .opcode_i (CU_OPCODE),
        .func3_i  (CU_FUNC3),
        .strb_o   (dec)
    );

    assign mret_now = (state_q == ST_EXEC) && dec.mret;

`ifdef OTTER_INTR_EN
    logic pend_q, pend_d;

    // An mret retiring this cycle defers a pending interrupt by one instruction.
    assign take_intr = pend_q && CU_MIE && !mret_now;

    // Entering INTR services the request, so it wins over a new CU_INTR.
    always_comb begin
        pend_d = pend_q | CU_INTR;
        if (state_d == ST_INTR) pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (RST) pend_q <= 1'b0;
        else     pend_q <= pend_d;
    end
`else
    logic unused_intr;
    assign unused_intr = ^{CU_INTR, CU_MIE, mret_now};
    assign take_intr   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_FETCH;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (dec.is_load)     state_d = ST_WB;
                else if (take_intr)  state_d = ST_INTR;
                else                 state_d = ST_FETCH;
            end
            ST_WB:   state_d = take_intr ? ST_INTR : ST_FETCH;
            ST_INTR: state_d = ST_FETCH;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        RST_OUT   = 1'b0;
        PC_WRITE  = 1'b0;
        REG_WRITE = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        CSR_WE    = 1'b0;
        INT_TAKEN = 1'b0;
        MRET_EXEC = 1'b0;
        case (state_q)
            ST_INIT:  RST_OUT   = 1'b1;
            ST_FETCH: MEM_RDEN1 = 1'b1;
            ST_EXEC: begin
                PC_WRITE  = dec.pc_write;
                REG_WRITE = dec.reg_write;
                MEM_RDEN2 = dec.mem_rden2;
                MEM_WE2   = dec.mem_we2;
                CSR_WE    = dec.csr_we;
                MRET_EXEC = dec.mret;
            end
            ST_WB: begin
                REG_WRITE = 1'b1;
                PC_WRITE  = 1'b1;
            end
            ST_INTR: begin
`ifdef OTTER_INTR_EN
                INT_TAKEN = 1'b1;
                PC_WRITE  = 1'b1;
`endif
            end
            default: ;
        endcase
        // A reset sampled this cycle must not let any architectural write land.
        if (RST) begin
            PC_WRITE  = 1'b0;
            REG_WRITE = 1'b0;
            MEM_WE2   = 1'b0;
            CSR_WE    = 1'b0;
            INT_TAKEN = 1'b0;
            MRET_EXEC = 1'b0;
        end
    end

    assign CU_STATE = state_q;

endmodule
